// File: rtl/data_mem.sv
// Byte-addressable little-endian data memory for the RV32I single-cycle core.
// Loads are combinational; stores commit on the rising edge with per-byte enables.
module data_mem #(
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        DMWr,
  input  logic [2:0]  DMCtrl,
  input  logic [31:0] addr,
  input  logic [31:0] DataWr,
  output logic [31:0] DataRd,
  output logic        misaligned
);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic          acc_byte;
  logic          acc_half;
  logic          acc_word;
  logic          acc_signed;
  logic          store_ok;
  logic [3:0]    byte_en;
  logic [31:0]   wdata;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;

  // Upper address bits are intentionally ignored so accesses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[31:AW+2];

  assign word_idx = addr[AW+1:2];
  assign lane     = addr[1:0];

  // 000/100 byte, 001/101 half, 010 word; 011/110/111 decode to nothing.
  assign acc_byte   = (DMCtrl[1:0] == 2'b00);
  assign acc_half   = (DMCtrl[1:0] == 2'b01);
  assign acc_word   = (DMCtrl == 3'b010);
  assign acc_signed = ~DMCtrl[2];

  assign misaligned = (acc_half & addr[0]) | (acc_word & (addr[1:0] != 2'b00));

  // Only the signed byte/half codes and word are legal store types.
  assign store_ok = DMWr & ~misaligned & acc_signed & (acc_byte | acc_half | acc_word);

  always_comb begin
    byte_en = 4'b0000;
    wdata   = DataWr;
    if (acc_byte) begin
      byte_en = 4'b0001 << lane;
      wdata   = {4{DataWr[7:0]}};
    end else if (acc_half) begin
      byte_en = lane[1] ? 4'b1100 : 4'b0011;
      wdata   = {2{DataWr[15:0]}};
    end else if (acc_word) begin
      byte_en = 4'b1111;
      wdata   = DataWr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (store_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[word_idx][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  assign rd_word = mem[word_idx];

  always_comb begin
    rd_byte = rd_word[lane*8 +: 8];
    rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    DataRd  = '0;
    if (!misaligned) begin
      if (acc_byte) begin
        DataRd = {{24{acc_signed & rd_byte[7]}}, rd_byte};
      end else if (acc_half) begin
        DataRd = {{16{acc_signed & rd_half[15]}}, rd_half};
      end else if (acc_word) begin
        DataRd = rd_word;
      end
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// Scoreboarded bench for data_mem: directed plan plus random ops against a
// byte-array reference model; a negedge monitor compares DataRd/misaligned.
module tb_data_mem;

  localparam int DEPTH = 256;
  localparam int NBYTES = DEPTH * 4;

  logic        clk;
  logic        rst_n;
  logic        DMWr;
  logic [2:0]  DMCtrl;
  logic [31:0] addr;
  logic [31:0] DataWr;
  logic [31:0] DataRd;
  logic        misaligned;

  data_mem #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .DMWr(DMWr), .DMCtrl(DMCtrl),
    .addr(addr), .DataWr(DataWr), .DataRd(DataRd), .misaligned(misaligned)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0] mem_m [NBYTES];
  int n_cmp = 0;
  int n_bad = 0;

  logic [32:0] exp_q[$];
  string       name_q[$];

  function automatic void model_clear();
    for (int i = 0; i < NBYTES; i++) mem_m[i] = 8'h00;
  endfunction

  function automatic bit ref_mis(logic [2:0] c, logic [31:0] a);
    if (c == 3'b001 || c == 3'b101) return a % 2 != 0;
    if (c == 3'b010) return a % 4 != 0;
    return 0;
  endfunction

  function automatic logic [31:0] ref_load(logic [2:0] c, logic [31:0] a);
    int unsigned b;
    byte         sb;
    shortint     sh;
    b = a % NBYTES;
    if (ref_mis(c, a)) return 32'h0;
    case (c)
      3'b000: begin sb = mem_m[b]; return 32'(int'(sb)); end
      3'b100: return {24'h0, mem_m[b]};
      3'b001: begin sh = {mem_m[b+1], mem_m[b]}; return 32'(int'(sh)); end
      3'b101: return {16'h0, mem_m[b+1], mem_m[b]};
      3'b010: return {mem_m[b+3], mem_m[b+2], mem_m[b+1], mem_m[b]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic void ref_store(logic [2:0] c, logic [31:0] a, logic [31:0] d);
    int unsigned b;
    b = a % NBYTES;
    if (ref_mis(c, a)) return;
    case (c)
      3'b000: mem_m[b] = d[7:0];
      3'b001: begin mem_m[b] = d[7:0]; mem_m[b+1] = d[15:8]; end
      3'b010: for (int k = 0; k < 4; k++) mem_m[b+k] = d[k*8 +: 8];
      default: ;
    endcase
  endfunction

  // ---------------- driver ----------------
  // One op per cycle: drive after posedge, expectation reflects memory before
  // the next edge; the model then absorbs the store that edge will commit.
  task automatic do_op(input string nm, input bit rst_val, input bit wr,
                       input logic [2:0] c, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    rst_n  = rst_val;
    DMWr   = wr;
    DMCtrl = c;
    addr   = a;
    DataWr = d;
    if (!rst_val) model_clear();
    exp_q.push_back({ref_mis(c, a), ref_load(c, a)});
    name_q.push_back(nm);
    if (rst_val && wr) ref_store(c, a, d);
  endtask

  task automatic ld(input string nm, input logic [2:0] c, input logic [31:0] a);
    do_op(nm, 1'b1, 1'b0, c, a, 32'h0);
  endtask

  task automatic st(input string nm, input logic [2:0] c, input logic [31:0] a, input logic [31:0] d);
    do_op(nm, 1'b1, 1'b1, c, a, d);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [32:0] e;
    string       nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_cmp++;
      if ({misaligned, DataRd} !== e) begin
        n_bad++;
        $display("FAIL %s: got mis=%0b data=%08h, expected mis=%0b data=%08h",
                 nm, misaligned, DataRd, e[32], e[31:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0]  rc;
    logic [31:0] ra;
    rst_n = 1'b0; DMWr = 1'b0; DMCtrl = 3'b010; addr = 32'h0; DataWr = 32'h0;
    model_clear();
    repeat (3) @(posedge clk);

    // 1: reset state and word store
    ld("lw_after_reset", 3'b010, 32'h4);
    st("sw_deadbeef", 3'b010, 32'h4, 32'hDEADBEEF);
    ld("lw_deadbeef", 3'b010, 32'h4);
    // 2: byte store and sign handling
    st("sb_aa", 3'b000, 32'h8, 32'h000000AA);
    ld("lb_aa", 3'b000, 32'h8);
    ld("lbu_aa", 3'b100, 32'h8);
    ld("lw_aa", 3'b010, 32'h8);
    // 3: half store and lane preservation
    st("sh_beef", 3'b001, 32'hC, 32'h0000BEEF);
    ld("lhu_beef", 3'b101, 32'hC);
    ld("lh_beef", 3'b001, 32'hC);
    st("sb_12_e", 3'b000, 32'hE, 32'h00000012);
    ld("lw_0012beef", 3'b010, 32'hC);
    ld("lh_upper", 3'b001, 32'hE);
    // 4: misalignment
    st("sw_misaligned", 3'b010, 32'h5, 32'h12345678);
    ld("lw_unchanged", 3'b010, 32'h4);
    ld("lh_mis", 3'b001, 32'h9);
    ld("lb_odd", 3'b000, 32'h9);
    ld("lw_mis2", 3'b010, 32'h6);
    // 5: illegal codes and wrap-around
    st("st_code100", 3'b100, 32'h4, 32'h11111111);
    st("st_code111", 3'b111, 32'h4, 32'h22222222);
    ld("lw_after_illegal", 3'b010, 32'h4);
    ld("ld_code011", 3'b011, 32'h4);
    st("sw_wrap", 3'b010, NBYTES + 32'h10, 32'hCAFEF00D);
    ld("lw_wrap", 3'b010, 32'h10);
    ld("lw_wrap_hi", 3'b010, 32'hFFFF_FC10);
    // 6: reset mid-operation, store held across a reset edge
    do_op("lw_in_reset", 1'b0, 1'b0, 3'b010, 32'h4, 32'h0);
    do_op("sw_in_reset", 1'b0, 1'b1, 3'b010, 32'h20, 32'h55AA55AA);
    ld("lw_after_release", 3'b010, 32'h20);
    ld("lw4_after_release", 3'b010, 32'h4);

    // random traffic over a small window so stores and loads collide
    for (int i = 0; i < 400; i++) begin
      rc = 3'($urandom_range(0, 7));
      ra = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) ra = ra | ($urandom & 32'hFFFF_FC00);
      if ($urandom_range(0, 79) == 0)
        do_op("rnd_reset", 1'b0, 1'($urandom_range(0, 1)), rc, ra, $urandom);
      else if ($urandom_range(0, 1) == 1)
        st("rnd_store", rc, ra, $urandom);
      else
        ld("rnd_load", rc, ra);
    end

    @(posedge clk);
    #1 DMWr = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // safety bound on total runtime
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_mem.md
Name: data_mem

Overview:
- Byte-addressable, little-endian data memory for the RV32I single-cycle core; services all load/store instructions.
- Loads are combinational (same cycle); stores commit on the rising clock edge.
- Access width and sign extension are selected by DMCtrl, encoded as the instruction funct3.

Parameters:
DEPTH, 256, number of 32-bit words (1 KiB); power of two, at least 4.
AW, log2(DEPTH), derived word-index width; not user-overridden.

Ports:
clk  input  1  clock; stores commit on the rising edge.
rst_n  input  1  asynchronous active-low reset.
DMWr  input  1  store enable.
DMCtrl  input  3  access type (funct3).
addr  input  32  byte address.
DataWr  input  32  store data; low byte or low half is used for narrow stores.
DataRd  output  32  load result, combinational.
misaligned  output  1  combinational flag: current DMCtrl/addr pair is misaligned.

Behaviour:

Reset:
- One clock domain.
- Reset is asynchronous and active-low: rst_n low immediately clears every memory word to 0, independent of clk.
- While rst_n is low, stores are blocked.
- A store coinciding with the edge on which rst_n is low is discarded.
- After reset deassertion, every load returns 0 until a location is written.

Addressing:
- Word index = addr[AW+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- Byte lane = addr[1:0]. Lane 0 is bits 7:0 (little-endian).

DMCtrl encoding:
- 000 = byte, signed (LB/SB).
- 001 = halfword, signed (LH/SH).
- 010 = word (LW/SW).
- 100 = byte, unsigned (LBU).
- 101 = halfword, unsigned (LHU).
- 011, 110, 111 = illegal.

Alignment:
- Halfword accesses need addr[0]=0.
- Word accesses need addr[1:0]=00.
- misaligned = 1 when a halfword or word access violates its alignment; otherwise 0 (including illegal codes).
- The flag is asserted regardless of DMWr.

Loads (combinational, zero latency, DMWr ignored):
- Byte: selected lane; signed codes replicate bit 7 into bits 31:8, unsigned codes zero-fill.
- Halfword: lane pair addr[1] (0 → bits 15:0, 1 → bits 31:16); signed codes replicate bit 15, unsigned codes zero-fill.
- Word: whole word.
- Misaligned access or illegal code: DataRd = 0.

Stores (on posedge clk when DMWr=1 and rst_n=1):
- 000: write DataWr[7:0] into the addressed lane only.
- 001: write DataWr[15:0] into the addressed half only.
- 010: write the full word.
- Other bytes of the word are preserved.
- 100, 101, 011, 110, 111: the store is ignored.
- Misaligned stores are ignored; memory is unchanged.

Read-during-write:
- DataRd shows the old contents until the edge.
- After the edge, DataRd reflects the new contents combinationally.
- No bypass is required.

Implementation and timing:
- No other state, no handshake.
- Memory is an array of DEPTH 32-bit words with per-byte write enables.

Test Plan:
1. Pulse rst_n low; LW addr 0x4 → DataRd 0x00000000. SW 0xDEADBEEF at 0x4 (DMWr=1 over one edge, drop after), then LW 0x4 → 0xDEADBEEF.
2. SB DataWr=0x000000AA at 0x8. LB 0x8 → 0xFFFFFFAA; LBU 0x8 → 0x000000AA; LW 0x8 → 0x000000AA (other lanes still 0).
3. SH DataWr=0x0000BEEF at 0xC. LHU 0xC → 0x0000BEEF; LH 0xC → 0xFFFFBEEF. SB 0x12 at 0xE, then LW 0xC → 0x0012BEEF (lane preservation, addr[1] half).
4. Misaligned: SW 0x12345678 at 0x5 → misaligned=1 and memory unchanged (LW 0x4 still 0xDEADBEEF). LH 0x9 → DataRd 0, misaligned=1. LB 0x9 → misaligned=0.
5. Illegal codes:
   - Store with DMCtrl=100 at 0x4 → ignored.
   - Load with DMCtrl=011 → 0.
   - Wrap-around: SW at address DEPTH*4+0x10, then LW 0x10 → same data.
6. Reset mid-operation:
   - Drop rst_n between edges → all loads return 0 immediately.
   - Hold DMWr=1 with rst_n=0 across an edge → no write after release.
